multiplier_sequencer: RTL
=========================

MULTIPLIER_SEQUENCER -- requirements
Module: multiplier_sequencer

Interface
REQ-001 Parameter N, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; sampled each rising edge.
REQ-005 inputM  input  N  multiplicand, unsigned; captured when start is accepted.
REQ-006 inputQ  input  N  multiplier, unsigned; captured when start is accepted.
REQ-007 busy  output  1  high while a multiply is in progress (RUN state).
REQ-008 done  output  1  single-cycle pulse; product valid and stable.
REQ-009 product  output  2N  unsigned product inputM*inputQ of last completed operation.

Function
REQ-010 FSM SHALL have exactly three states: IDLE, RUN, DONE; encoding free.
REQ-011 IDLE: start=1 at edge -> capture inputM into M register, inputQ into Q register, clear accumulator A (N+1 bits), load cycle counter with N-1, go RUN.
REQ-012 IDLE: start=0 -> remain IDLE; all registers hold.
REQ-013 RUN, each edge: if Q[0]=1 then {A,Q} <= ({A + {0,M}}, Q) shifted right by one, else {A,Q} shifted right by one; carry out of addition enters A MSB before shift.
REQ-014 RUN: counter decrements each edge; at edge where counter=0, perform final step and go DONE.
REQ-015 RUN SHALL last exactly N edges; start during RUN SHALL be ignored, operands not re-captured.
REQ-016 DONE: lasts one cycle, unconditionally returns to IDLE; start during DONE SHALL be ignored.
REQ-017 product SHALL equal {A[N-1:0], Q} and update only on the edge entering DONE; held unchanged through IDLE until the next completion.
REQ-018 busy = 1 iff state is RUN; done = 1 iff state is DONE; both registered-state decodes, no combinational path from start.
REQ-019 Latency: start accepted at edge k -> busy high from k to k+N, done high for the cycle after edge k+N, product valid from edge k+N.
REQ-020 Throughput: next start accepted no earlier than edge k+N+2; peak one result per N+2 cycles.
REQ-021 inputM/inputQ changes after acceptance SHALL not affect the result.
REQ-022 Arithmetic exact for all operands including 0 and 2^N-1; no overflow since product is 2N bits and A is N+1 bits.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, clear A, M, Q, counter, product to 0; busy=0, done=0 from that edge.
REQ-024 reset SHALL take priority over start and over any in-progress RUN; aborted operation produces no done pulse.
REQ-025 start asserted on same edge as reset SHALL be ignored; first acceptable start is at the edge after reset deasserts.

Verification (N=8)
REQ-026 Reset, then start with inputM=0xFF, inputQ=0xFF at edge k -> busy high k..k+8, done pulse in cycle after edge k+8, product=0xFE01.
REQ-027 inputM=13, inputQ=11 -> product=143 (0x008F); inputM=0x00, inputQ=0xA5 -> product=0x0000, done still at k+8.
REQ-028 Start accepted with 0x12*0x34, start held high and inputs changed to 0xFF*0xFF during RUN and DONE -> single done, product=0x03A8, next operation (0xFF*0xFF) accepted at edge after DONE -> product 0xFE01.
REQ-029 Start 0xFF*0xFF, assert reset at edge k+4 -> busy=0, product=0, no done pulse; subsequent start 0x02*0x03 -> product=0x0006.
REQ-030 Random regression, 1000 operand pairs, back-to-back at maximum throughput -> every product matches reference model; done count equals accepted start count.

Source files
------------

// File: rtl/multiplier_sequencer_if.sv
// rtl/multiplier_sequencer_if.sv - request/result bundle for the shift-add multiplier
interface multiplier_sequencer_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   inputM;
  logic [N-1:0]   inputQ;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, inputM, inputQ,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, inputM, inputQ,
    output busy, done, product
  );
endinterface

// File: rtl/multiplier_sequencer.sv
// rtl/multiplier_sequencer.sv - sequential shift-add unsigned multiplier, one bit per cycle
module multiplier_sequencer #(
  parameter int N = 8
) (
  input logic                  clk,
  input logic                  reset,
  multiplier_sequencer_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT          state;
  stateT          nextState;
  logic [N:0]     regA;
  logic [N-1:0]   regM;
  logic [N-1:0]   regQ;
  logic [CW-1:0]  count;
  logic [2*N-1:0] productReg;
  logic [N:0]     sumA;
  logic [2*N:0]   stepAQ;

  // State register; reset wins over everything, including a start on the same edge
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state: RUN exits on the edge where the counter has reached zero
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.start) nextState = RUN;
      RUN:     if (count == '0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs decode only the registered state, never start
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // One shift-add step: conditional add of M (carry kept in A's top bit), then shift {A,Q} right
  always_comb begin
    sumA = regA + {1'b0, regM};
    if (regQ[0]) stepAQ = {sumA, regQ} >> 1;
    else         stepAQ = {regA, regQ} >> 1;
  end

  // Datapath: capture operands on accept, iterate in RUN, publish product on the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      regA       <= '0;
      regM       <= '0;
      regQ       <= '0;
      count      <= '0;
      productReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            regM  <= bus.inputM;
            regQ  <= bus.inputQ;
            regA  <= '0;
            count <= CW'(N - 1);
          end
        end
        RUN: begin
          regA  <= stepAQ[2*N:N];
          regQ  <= stepAQ[N-1:0];
          count <= count - 1'b1;
          if (count == '0) productReg <= stepAQ[2*N-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.product = productReg;
endmodule
